// File: rtl/id_operand_stage.sv
// rtl/id_operand_stage.sv - decode-to-execute operand stage: forwarding, load-use stall, pipeline register
module id_operand_stage #(
    parameter int dataW = 32,
    parameter int idxW  = 5,
    parameter int cntW  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [idxW-1:0]  in_rs1,
    input  logic [idxW-1:0]  in_rs2,
    input  logic             in_uses_rs1,
    input  logic             in_uses_rs2,
    input  logic [idxW-1:0]  in_rd,
    input  logic             in_rd_we,
    input  logic [dataW-1:0] in_imm,
    input  logic [dataW-1:0] in_pc,
    input  logic [7:0]       in_ctrl,
    output logic [idxW-1:0]  RegData1,
    output logic [idxW-1:0]  RegData2,
    input  logic [dataW-1:0] RegDataOut1,
    input  logic [dataW-1:0] RegDataOut2,
    input  logic             ex_valid,
    input  logic [idxW-1:0]  ex_rd,
    input  logic             ex_is_load,
    input  logic [dataW-1:0] ex_data,
    input  logic             wb_we,
    input  logic [idxW-1:0]  wb_rd,
    input  logic [dataW-1:0] wb_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [dataW-1:0] out_op1,
    output logic [dataW-1:0] out_op2,
    output logic [dataW-1:0] out_imm,
    output logic [dataW-1:0] out_pc,
    output logic [7:0]       out_ctrl,
    output logic [idxW-1:0]  out_rd,
    output logic             out_rd_we,
    output logic [cntW-1:0]  bubble_count
);

    logic             valid_q, valid_d;
    logic [dataW-1:0] op1_q, op1_d, op2_q, op2_d, imm_q, imm_d, pc_q, pc_d;
    logic [7:0]       ctrl_q, ctrl_d;
    logic [idxW-1:0]  rd_q, rd_d;
    logic             rd_we_q, rd_we_d;
    logic [cntW-1:0]  bubble_q, bubble_d;

    logic             hazard, advance, accept;
    logic             hz_rs1, hz_rs2;
    logic [dataW-1:0] op1_res, op2_res;

    // EX beats WB: EX holds the younger write to the same register.
    function automatic logic [dataW-1:0] resolve(input logic [idxW-1:0]  rs,
                                                 input logic [dataW-1:0] rf_data);
        if (rs == '0)
            return '0;
        else if (ex_valid && !ex_is_load && ex_rd == rs)
            return ex_data;
        else if (wb_we && wb_rd == rs)
            return wb_data;
        else
            return rf_data;
    endfunction

    assign RegData1 = in_rs1;
    assign RegData2 = in_rs2;
    assign op1_res  = resolve(in_rs1, RegDataOut1);
    assign op2_res  = resolve(in_rs2, RegDataOut2);

    assign hz_rs1   = in_uses_rs1 && in_rs1 == ex_rd && ex_rd != '0;
    assign hz_rs2   = in_uses_rs2 && in_rs2 == ex_rd && ex_rd != '0;
    assign hazard   = in_valid && ex_valid && ex_is_load && (hz_rs1 || hz_rs2);
    assign advance  = !valid_q || out_ready;
    assign in_ready = advance && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d  = valid_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        imm_d    = imm_q;
        pc_d     = pc_q;
        ctrl_d   = ctrl_q;
        rd_d     = rd_q;
        rd_we_d  = rd_we_q;
        bubble_d = bubble_q;
        if (flush)
            valid_d = 1'b0;
        else if (advance)
            valid_d = accept;
        if (accept) begin
            op1_d   = op1_res;
            op2_d   = op2_res;
            imm_d   = in_imm;
            pc_d    = in_pc;
            ctrl_d  = in_ctrl;
            rd_d    = in_rd;
            rd_we_d = in_rd_we;
        end
        if (hazard && advance && !flush && bubble_q != '1)
            bubble_d = bubble_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            ctrl_q   <= '0;
            rd_q     <= '0;
            rd_we_q  <= 1'b0;
            bubble_q <= '0;
        end else begin
            valid_q  <= valid_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            imm_q    <= imm_d;
            pc_q     <= pc_d;
            ctrl_q   <= ctrl_d;
            rd_q     <= rd_d;
            rd_we_q  <= rd_we_d;
            bubble_q <= bubble_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_op1      = op1_q;
    assign out_op2      = op2_q;
    assign out_imm      = imm_q;
    assign out_pc       = pc_q;
    assign out_ctrl     = ctrl_q;
    assign out_rd       = rd_q;
    assign out_rd_we    = rd_we_q;
    assign bubble_count = bubble_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// tb/tb_id_operand_stage.sv - scoreboard bench for id_operand_stage
module tb_id_operand_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_uses_rs1, in_uses_rs2, in_rd_we;
    logic [31:0] in_imm, in_pc;
    logic [7:0]  in_ctrl;
    logic [4:0]  RegData1, RegData2;
    logic [31:0] RegDataOut1, RegDataOut2;
    logic        ex_valid, ex_is_load;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_op1, out_op2, out_imm, out_pc;
    logic [7:0]  out_ctrl;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [15:0] bubble_count;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [7:0]  ctrl;
        logic [4:0]  rd;
        logic        rd_we;
    } exp_t;

    exp_t        sb[$];
    logic        m_valid;
    logic [15:0] m_bubble;
    int          n_checks = 0;
    int          n_fail = 0;

    id_operand_stage dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
        .in_rd(in_rd), .in_rd_we(in_rd_we),
        .in_imm(in_imm), .in_pc(in_pc), .in_ctrl(in_ctrl),
        .RegData1(RegData1), .RegData2(RegData2),
        .RegDataOut1(RegDataOut1), .RegDataOut2(RegDataOut2),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_data(ex_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm), .out_pc(out_pc),
        .out_ctrl(out_ctrl), .out_rd(out_rd), .out_rd_we(out_rd_we),
        .bubble_count(bubble_count)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] m_resolve(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 5'd0) return 32'd0;
        if (ex_valid && !ex_is_load && ex_rd == rs) return ex_data;
        if (wb_we && wb_rd == rs) return wb_data;
        return rf;
    endfunction

    task automatic check_all_zero(input string tag);
        check_val({tag, "_valid"}, out_valid, 0);
        check_val({tag, "_op1"}, out_op1, 0);
        check_val({tag, "_op2"}, out_op2, 0);
        check_val({tag, "_imm"}, out_imm, 0);
        check_val({tag, "_pc"}, out_pc, 0);
        check_val({tag, "_ctrl"}, out_ctrl, 0);
        check_val({tag, "_rd"}, out_rd, 0);
        check_val({tag, "_rd_we"}, out_rd_we, 0);
        check_val({tag, "_bubble"}, bubble_count, 0);
    endtask

    // One clock: check at the falling edge, update the model, return 1 after the rising edge.
    task automatic cycle();
        logic hz, adv, acc;
        exp_t e;
        @(negedge clock);
        hz  = in_valid && ex_valid && ex_is_load &&
              ((in_uses_rs1 && in_rs1 == ex_rd && ex_rd != 0) ||
               (in_uses_rs2 && in_rs2 == ex_rd && ex_rd != 0));
        adv = !m_valid || out_ready;
        acc = in_valid && adv && !hz && !flush;
        check_val("out_valid", out_valid, m_valid);
        check_val("in_ready", in_ready, adv && !hz && !flush);
        check_val("bubble_count", bubble_count, m_bubble);
        check_val("RegData1", RegData1, in_rs1);
        check_val("RegData2", RegData2, in_rs2);
        if (m_valid && out_ready) begin
            if (sb.size() == 0) check_val("sb_empty", sb.size(), 1);
            else begin
                e = sb.pop_front();
                check_val("sb_op1", out_op1, e.op1);
                check_val("sb_op2", out_op2, e.op2);
                check_val("sb_imm", out_imm, e.imm);
                check_val("sb_pc", out_pc, e.pc);
                check_val("sb_ctrl", out_ctrl, e.ctrl);
                check_val("sb_rd", out_rd, e.rd);
                check_val("sb_rd_we", out_rd_we, e.rd_we);
            end
        end else if (m_valid && flush && sb.size() != 0) begin
            void'(sb.pop_front());
        end
        if (hz && adv && !flush && m_bubble != 16'hFFFF) m_bubble++;
        if (flush) m_valid = 1'b0;
        else if (adv) m_valid = acc;
        if (acc) begin
            e.op1 = m_resolve(in_rs1, RegDataOut1);
            e.op2 = m_resolve(in_rs2, RegDataOut2);
            e.imm = in_imm; e.pc = in_pc; e.ctrl = in_ctrl;
            e.rd = in_rd; e.rd_we = in_rd_we;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2, input logic [4:0] rd);
        in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; RegDataOut1 = d1; RegDataOut2 = d2;
        in_uses_rs1 = 1'b1; in_uses_rs2 = 1'b1; in_rd = rd; in_rd_we = 1'b1;
        in_imm = $urandom; in_pc = $urandom; in_ctrl = 8'($urandom);
    endtask

    initial begin
        reset = 1'b1; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_uses_rs1 = 0; in_uses_rs2 = 0;
        in_rd = 0; in_rd_we = 0; in_imm = 0; in_pc = 0; in_ctrl = 0;
        RegDataOut1 = 0; RegDataOut2 = 0; ex_valid = 0; ex_rd = 0; ex_is_load = 0; ex_data = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0; flush = 0; out_ready = 1;
        m_valid = 0; m_bubble = 0;
        #1 reset = 1'b0;
        #1 check_all_zero("reset");
        @(posedge clock); #1 reset = 1'b1;

        // plain issue
        issue(5'd3, 32'h11, 5'd4, 32'h22, 5'd10);
        cycle();
        check_val("plain_valid", out_valid, 1);
        check_val("plain_op1", out_op1, 32'h11);
        check_val("plain_op2", out_op2, 32'h22);

        // forward priority: EX over WB over regfile, x0 always zero
        issue(5'd5, 32'h1234, 5'd9, 32'h99, 5'd11);
        ex_valid = 1; ex_rd = 5; ex_data = 32'hAAAA; wb_we = 1; wb_rd = 5; wb_data = 32'hBBBB;
        cycle();
        check_val("fwd_ex_op1", out_op1, 32'hAAAA);
        check_val("fwd_ex_op2", out_op2, 32'h99);
        ex_valid = 0;
        cycle();
        check_val("fwd_wb_op1", out_op1, 32'hBBBB);
        issue(5'd0, 32'h7777, 5'd9, 32'h99, 5'd12);
        wb_rd = 0; wb_data = 32'hCCCC;
        cycle();
        check_val("fwd_x0_op1", out_op1, 32'h0);
        wb_we = 0;

        // load-use stall, then bypass from WB
        issue(5'd2, 32'h20, 5'd7, 32'hDEAD, 5'd13);
        ex_valid = 1; ex_is_load = 1; ex_rd = 7;
        cycle();
        check_val("lu_bubble_valid", out_valid, 0);
        check_val("lu_bubble_cnt", bubble_count, 1);
        ex_valid = 0; wb_we = 1; wb_rd = 7; wb_data = 32'h55;
        cycle();
        check_val("lu_wb_valid", out_valid, 1);
        check_val("lu_wb_op2", out_op2, 32'h55);
        wb_we = 0;
        issue(5'd2, 32'h20, 5'd7, 32'hDEAD, 5'd14);
        in_uses_rs2 = 0; ex_valid = 1; ex_is_load = 1; ex_rd = 7;
        cycle();
        check_val("lu_unused_valid", out_valid, 1);
        check_val("lu_unused_cnt", bubble_count, 1);
        ex_valid = 0; ex_is_load = 0;
        in_valid = 0;
        cycle();

        // backpressure
        out_ready = 0;
        issue(5'd1, 32'h100, 5'd2, 32'h200, 5'd15);
        cycle();
        issue(5'd3, 32'h300, 5'd4, 32'h400, 5'd16);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_val("bp_hold_op1", out_op1, 32'h100);
            check_val("bp_hold_op2", out_op2, 32'h200);
            check_val("bp_hold_valid", out_valid, 1);
        end
        out_ready = 1;
        cycle();
        check_val("bp_next_op1", out_op1, 32'h300);
        in_valid = 0;
        cycle();

        // flush kills held and incoming
        out_ready = 0;
        issue(5'd6, 32'h600, 5'd8, 32'h800, 5'd17);
        cycle();
        issue(5'd9, 32'h900, 5'd8, 32'h800, 5'd18);
        flush = 1;
        cycle();
        check_val("flush_valid", out_valid, 0);
        check_val("flush_cnt", bubble_count, 1);
        flush = 0; in_valid = 0; out_ready = 1;
        cycle();

        // saturate the bubble counter with a sustained load-use stall
        issue(5'd2, 32'h20, 5'd7, 32'h70, 5'd19);
        ex_valid = 1; ex_is_load = 1; ex_rd = 7;
        repeat (65540) begin
            @(posedge clock);
            if (m_bubble != 16'hFFFF) m_bubble++;
        end
        m_valid = 1'b0;
        #1;
        check_val("sat_cnt", bubble_count, 16'hFFFF);
        cycle();
        check_val("sat_hold_cnt", bubble_count, 16'hFFFF);

        // async reset while a held instruction is stalled
        ex_valid = 0; ex_is_load = 0; out_ready = 0;
        issue(5'd3, 32'h33, 5'd4, 32'h44, 5'd20);
        cycle();
        check_val("pre_rst_valid", out_valid, 1);
        issue(5'd5, 32'h55, 5'd6, 32'h66, 5'd21);
        cycle();
        #2 reset = 1'b0;
        #1 check_all_zero("async_rst");
        sb.delete(); m_valid = 0; m_bubble = 0;
        #3 reset = 1'b1;
        in_valid = 0; out_ready = 1;
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Decode-to-execute operand stage. It drives the register file read indexes from the decoded instruction and takes back the two read data words.
- It resolves forwarding from the EX and WB stages and detects load-use hazards.
- It holds the resolved operands in a one-entry valid/ready pipeline register that feeds the ALU/execute stage.
- It also counts inserted bubbles for performance monitoring.

Parameters:
- dataW, 32, data/operand width
- idxW, 5, register index width (32 architectural registers, x0 hard-wired zero)
- cntW, 16, bubble counter width

Ports:
- clock  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- in_valid  input  1  decoded instruction present
- in_ready  output  1  stage accepts the instruction this cycle
- in_rs1, in_rs2  input  idxW  source register indexes
- in_uses_rs1, in_uses_rs2  input  1  source actually read by the instruction
- in_rd  input  idxW  destination index
- in_rd_we  input  1  instruction writes rd
- in_imm  input  dataW  decoded immediate
- in_pc  input  dataW  instruction PC
- in_ctrl  input  8  opaque execute control bits
- RegData1, RegData2  output  idxW  register file read indexes
- RegDataOut1, RegDataOut2  input  dataW  register file read data (combinational)
- ex_valid  input  1  EX holds a valid instruction writing ex_rd
- ex_rd  input  idxW  EX destination
- ex_is_load  input  1  EX instruction is a load (result not yet available)
- ex_data  input  dataW  EX ALU result
- wb_we  input  1  writeback active this cycle
- wb_rd  input  idxW  writeback destination
- wb_data  input  dataW  writeback data
- flush  input  1  kill held and incoming instruction (branch/jump redirect)
- out_valid  output  1  operands valid
- out_ready  input  1  execute consumes this cycle
- out_op1, out_op2  output  dataW  resolved operands
- out_imm, out_pc  output  dataW  registered copies
- out_ctrl  output  8  registered copy
- out_rd  output  idxW  registered copy
- out_rd_we  output  1  registered copy
- bubble_count  output  cntW  saturating count of load-use bubbles

Behaviour:
- RegData1 = in_rs1 and RegData2 = in_rs2, both combinational.
- Operand resolution (per source, combinational), priority order:
  - rs==0: result is 0.
  - ex_valid && !ex_is_load && ex_rd==rs: result is ex_data.
  - wb_we && wb_rd==rs: result is wb_data. The register file write lands at the clock edge, so a same-cycle read returns the stale value and must be bypassed.
  - Otherwise: result is RegDataOut.
- hazard = in_valid && ex_valid && ex_is_load && ((in_uses_rs1 && in_rs1==ex_rd && ex_rd!=0) || (in_uses_rs2 && in_rs2==ex_rd && ex_rd!=0)).
- advance = !out_valid || out_ready.
- in_ready = advance && !hazard && !flush.
- Accept (in_valid && in_ready): at the next edge load all out_* fields from the resolved operands and inputs; out_valid=1.
- advance && !accept: out_valid=0 at the next edge, which is a bubble. Data fields hold their values (don't-care).
- !advance: all out_* hold.
- flush dominates everything: at the next edge out_valid=0, and nothing is accepted in the flush cycle.
- bubble_count increments by 1 on each edge where hazard && advance && !flush. It saturates at all-ones and never wraps.
- Reset (async, reset=0):
  - out_valid=0.
  - out_op1, out_op2, out_imm, out_pc, out_ctrl, out_rd, out_rd_we all 0.
  - bubble_count=0.
  - Reset mid-stall discards the held instruction.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 per cycle when out_ready is held high.

Test Plan:
- Plain issue:
  - Stimulus: rs1=3, rs2=4, RegDataOut1=0x11, RegDataOut2=0x22, no forwards, out_ready=1.
  - Response: next cycle out_valid=1, out_op1=0x11, out_op2=0x22.
- Forward priority:
  - Stimulus: rs1=5 with ex_rd=5, ex_data=0xAAAA, and wb_rd=5, wb_data=0xBBBB.
  - Response: out_op1=0xAAAA.
  - Stimulus: with ex_valid=0 instead.
  - Response: out_op1=0xBBBB.
  - Stimulus: rs1=0 with wb_rd=0.
  - Response: out_op1=0.
- Load-use:
  - Stimulus: ex_is_load=1, ex_rd=7, in_rs2=7, in_uses_rs2=1.
  - Response: in_ready=0, one bubble (out_valid=0), bubble_count 0->1.
  - Stimulus: next cycle ex_valid=0, wb_rd=7, wb_data=0x55.
  - Response: accepted, out_op2=0x55.
  - Stimulus: the same hazard pattern with in_uses_rs2=0.
  - Response: no stall.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles while holding an instruction.
  - Response: out_* stable and in_ready=0. Once out_ready=1, the held instruction completes and the next one is accepted the same cycle.
- Flush:
  - Stimulus: flush=1 while out_valid=1 and in_valid=1.
  - Response: next cycle out_valid=0, input not accepted, bubble_count unchanged.
- Async reset:
  - Stimulus: drive reset=0 mid-stall with bubble_count at 0xFFFF, which must not have wrapped beforehand.
  - Response: all outputs 0 immediately, with no clock edge needed.
